// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 FFT datapath: sample type, sizing helpers
// and the radix-4 digit reversal used to undo the SDF output ordering.
package fft_pkg;
    localparam int FFT_WIDTH  = 32;
    localparam int MAX_ADDR_W = 16;

    typedef struct packed {
        logic [FFT_WIDTH-1:0] re;
        logic [FFT_WIDTH-1:0] im;
    } sample_t;

    function automatic int clog2_c(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Least-significant digit is shifted in first, so it lands at the top of the addr_w field.
    function automatic logic [MAX_ADDR_W-1:0] digit_rev(input logic [MAX_ADDR_W-1:0] index,
                                                        input int addr_w);
        logic [MAX_ADDR_W-1:0] result;
        logic [MAX_ADDR_W-1:0] src;
        result = '0;
        src    = index;
        for (int d = 0; d < MAX_ADDR_W / 32'sd2; d++) begin
            if (d < addr_w / 32'sd2) begin
                result = {result[MAX_ADDR_W-3:0], src[1:0]};
                src    = {2'b00, src[MAX_ADDR_W-1:2]};
            end else begin
                result = result;
                src    = src;
            end
        end
        return result;
    endfunction
endpackage

// File: rtl/reorder_bank_ram.sv
// Ping-pong sample storage: two banks of 2^ADDR_W words, one write and one
// asynchronous read port, both addressed by {bank, addr}.
module reorder_bank_ram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = 32'd2 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Sample write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];
endmodule

// File: rtl/fft_output_reorder.sv
// Captures digit-reversed FFT frames into ping-pong banks and streams them out
// in natural frequency order over a valid/ready interface.
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int N     = 64,
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_imag,
    output logic             out_last,
    output logic             overflow
);
    localparam int                ADDR_W   = clog2_c(N);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    logic [ADDR_W-1:0]  wcnt_r;
    logic [ADDR_W-1:0]  rcnt_r;
    logic               wbank_r;
    logic               rbank_r;
    logic [1:0]         full_r;
    logic               wr_en_s;
    logic               wr_done_s;
    logic               fetch_s;
    logic               rd_done_s;
    logic [1:0]         set_mask_s;
    logic [1:0]         clr_mask_s;
    logic [ADDR_W-1:0]  rd_idx_s;
    logic [2*WIDTH-1:0] rd_data_s;

    assign wr_en_s    = in_valid && !full_r[wbank_r];
    assign wr_done_s  = wr_en_s && (wcnt_r == LAST_IDX);
    assign fetch_s    = full_r[rbank_r] && (!out_valid || out_ready);
    assign rd_done_s  = fetch_s && (rcnt_r == LAST_IDX);
    assign rd_idx_s   = ADDR_W'(digit_rev(MAX_ADDR_W'(rcnt_r), ADDR_W));
    // Writer only completes an empty bank and reader only drains a full one, so the masks never overlap.
    assign set_mask_s = {wr_done_s & wbank_r, wr_done_s & ~wbank_r};
    assign clr_mask_s = {rd_done_s & rbank_r, rd_done_s & ~rbank_r};

    reorder_bank_ram #(
        .DATA_W (2 * WIDTH),
        .ADDR_W (ADDR_W)
    ) u_bank_ram (
        .clock   (clock),
        .wr_en   (wr_en_s),
        .wr_addr ({wbank_r, wcnt_r}),
        .wr_data ({in_real, in_imag}),
        .rd_addr ({rbank_r, rd_idx_s}),
        .rd_data (rd_data_s)
    );

    // Write side: sample capture, bank rotation and sticky overflow.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wcnt_r   <= '0;
            wbank_r  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wcnt_r <= wcnt_r + 1'b1;
                if (wr_done_s) begin
                    wbank_r <= ~wbank_r;
                end
            end
            if (in_valid && full_r[wbank_r]) begin
                overflow <= 1'b1;
            end
        end
    end

    // Bank occupancy flags.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            full_r <= 2'b00;
        end else begin
            full_r <= (full_r | set_mask_s) & ~clr_mask_s;
        end
    end

    // Read side: natural-order fetch into the output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rcnt_r    <= '0;
            rbank_r   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
        end else if (fetch_s) begin
            rcnt_r    <= rcnt_r + 1'b1;
            if (rd_done_s) begin
                rbank_r <= ~rbank_r;
            end
            out_valid <= 1'b1;
            out_last  <= rd_done_s;
            out_real  <= rd_data_s[2*WIDTH-1:WIDTH];
            out_imag  <= rd_data_s[WIDTH-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_output_reorder.sv
// Self-checking bench for fft_output_reorder: a frame-level reference model,
// a table of known digit-reversal points and directed corner-case sequences.
module tb_fft_output_reorder;
    localparam int N      = 64;
    localparam int W      = 32;
    localparam int DIGITS = 3;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         last;
    } exp_t;

    typedef struct {
        int           f;
        logic [W-1:0] want_re;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [W-1:0] in_real;
    logic [W-1:0] in_imag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_real;
    logic [W-1:0] out_imag;
    logic         out_last;
    logic         overflow;

    exp_t         exp_q[$];
    logic [W-1:0] frame_re[$];
    logic [W-1:0] frame_im[$];
    logic [W-1:0] cap_q[$];
    vec_t         vecs[8];

    int tests = 0;
    int fails = 0;
    int gap_cnt = 0;
    bit gap_watch = 1'b0;
    bit seen_v = 1'b0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_re;
    logic [W-1:0] prev_im;
    logic         prev_last;

    fft_output_reorder #(
        .N     (N),
        .WIDTH (W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int rev_model(input int idx);
        int r;
        int v;
        r = 0;
        v = idx;
        for (int d = 0; d < DIGITS; d++) begin
            r = r * 4 + v % 4;
            v = v / 4;
        end
        return r;
    endfunction

    // A completed frame is emitted in natural order: output f carries input sample rev(f).
    task automatic model_push(input logic [W-1:0] re, input logic [W-1:0] im);
        exp_t e;
        frame_re.push_back(re);
        frame_im.push_back(im);
        if (frame_re.size() == N) begin
            for (int f = 0; f < N; f++) begin
                e.re   = frame_re[rev_model(f)];
                e.im   = frame_im[rev_model(f)];
                e.last = (f == N - 1);
                exp_q.push_back(e);
            end
            frame_re.delete();
            frame_im.delete();
        end
    endtask

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input bit accepted);
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        if (accepted) model_push(re, im);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < bound) begin
            @(negedge clock);
            #1;
            guard++;
        end
        check(name, 128'(exp_q.size()), 128'(0));
        @(posedge clock);
        #1;
    endtask

    // Output monitor: scoreboard on transfers, hold check on stalls, gap counting.
    always @(negedge clock) begin
        exp_t e;
        if (prev_stall) begin
            check("stall_hold", 128'({out_valid, out_last, out_real, out_imag}),
                  128'({1'b1, prev_last, prev_re, prev_im}));
        end
        prev_stall = reset_n && out_valid && !out_ready;
        prev_re    = out_real;
        prev_im    = out_imag;
        prev_last  = out_last;
        if (gap_watch) begin
            if (out_valid) seen_v = 1'b1;
            else if (seen_v) gap_cnt++;
        end
        if (reset_n && out_valid && out_ready) begin
            cap_q.push_back(out_real);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_output: got real %0h with nothing expected", out_real);
            end else begin
                e = exp_q.pop_front();
                check("out_sample", 128'({out_last, out_real, out_imag}), 128'({e.last, e.re, e.im}));
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Test sequence.
    initial begin
        vecs[0] = '{0,  32'd0};
        vecs[1] = '{1,  32'd16};
        vecs[2] = '{2,  32'd32};
        vecs[3] = '{3,  32'd48};
        vecs[4] = '{4,  32'd4};
        vecs[5] = '{5,  32'd20};
        vecs[6] = '{6,  32'd36};
        vecs[7] = '{63, 32'd63};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_last",  128'(out_last),  128'(1'b0));
        check("rst_overflow",  128'(overflow),  128'(1'b0));
        check("rst_out_real",  128'(out_real),  128'(32'd0));
        check("rst_out_imag",  128'(out_imag),  128'(32'd0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single frame with known ramp data and latency checks.
        out_ready = 1'b1;
        cap_q.delete();
        for (int k = 0; k < N; k++) send(W'(k), ~W'(k), 1'b1);
        check("latency_early", 128'(out_valid), 128'(1'b0));
        @(posedge clock);
        #1;
        check("latency_first_valid", 128'(out_valid), 128'(1'b1));
        check("latency_first_real",  128'(out_real),  128'(32'd0));
        wait_drain("t1_drain", 200);
        check("t1_count", 128'(cap_q.size()), 128'(N));
        for (int i = 0; i < 8; i++) begin
            if (cap_q.size() > vecs[i].f)
                check($sformatf("t1_rev_%0d", vecs[i].f), 128'(cap_q[vecs[i].f]), 128'(vecs[i].want_re));
        end
        check("t1_overflow", 128'(overflow), 128'(1'b0));

        // Three back-to-back frames at full rate.
        gap_cnt   = 0;
        seen_v    = 1'b0;
        gap_watch = 1'b1;
        for (int k = 0; k < 3 * N; k++) send($urandom, $urandom, 1'b1);
        wait_drain("t2_drain", 400);
        gap_watch = 1'b0;
        check("t2_gaps", 128'(gap_cnt), 128'(0));
        check("t2_overflow", 128'(overflow), 128'(1'b0));

        // Random backpressure on a single frame.
        for (int k = 0; k < N; k++) begin
            out_ready = ($urandom_range(0, 1) == 1);
            send(W'(k), ~W'(k), 1'b1);
        end
        for (int g = 0; g < 2000 && exp_q.size() != 0; g++) begin
            out_ready = ($urandom_range(0, 1) == 1);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        wait_drain("t3_drain", 10);

        // Overflow: two frames fill both banks, the next sample is dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 2 * N; k++) send($urandom, $urandom, 1'b1);
        check("ovf_before", 128'(overflow), 128'(1'b0));
        send($urandom, $urandom, 1'b0);
        check("ovf_after", 128'(overflow), 128'(1'b1));
        out_ready = 1'b1;
        wait_drain("t4_drain", 400);
        check("ovf_sticky", 128'(overflow), 128'(1'b1));

        // Reset mid-frame while the previous frame is half read.
        for (int k = 0; k < N + 30; k++) send($urandom, $urandom, 1'b1);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_valid",    128'(out_valid), 128'(1'b0));
        check("midrst_overflow", 128'(overflow),  128'(1'b0));
        exp_q.delete();
        frame_re.delete();
        frame_im.delete();
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) send(W'(k), ~W'(k), 1'b1);
        wait_drain("t5_drain", 200);
        check("t5_overflow", 128'(overflow), 128'(1'b0));

        // Gapped input at one valid sample in three.
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) check("gap_no_early", 128'(out_valid), 128'(1'b0));
            send($urandom, $urandom, 1'b1);
            repeat (2) begin
                @(posedge clock);
                #1;
            end
        end
        wait_drain("t6_drain", 200);
        check("t6_overflow", 128'(overflow), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
